fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch sequencer for the multicycle RV32I core.
- Sits between the PC register and instruction memory.
- Reads the current PC, issues a req/gnt/rvalid memory read, captures the instruction for the controller, and drives PC_next/PCWrite back into the PC register (PC+4 or branch redirect target).
- It is the write side of the PC interface: the only source of PCWrite during fetch.

Parameters:
- XLEN, 32: address/data width.
- INCR, 4: sequential PC increment in bytes.
- RESET_VEC, 32'h0000_0020: reset value of instr_pc; matches the PC register reset vector.
- CNT_W, 32: width of the retired-fetch counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  current PC (PC register output).
- PC_next  out  XLEN  next PC value to the PC register.
- PCWrite  out  1  one-cycle PC load strobe.
- fetch_en  in  1  controller requests the next instruction.
- redirect  in  1  branch/jump taken, one-cycle pulse.
- redirect_target  in  XLEN  target PC, valid with redirect.
- imem_req  out  1  memory read request.
- imem_addr  out  XLEN  read address.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  read data.
- instr  out  XLEN  captured instruction.
- instr_pc  out  XLEN  PC of the captured instruction.
- instr_valid  out  1  instr/instr_pc valid, held until instr_ack.
- instr_ack  in  1  controller consumed instr.
- misalign_err  out  1  fetch PC not word aligned; sticky until instr_ack or redirect.
- fetch_cnt  out  CNT_W  count of delivered instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; PCWrite=0, PC_next=0, imem_req=0, imem_addr=0, instr=0, instr_pc=RESET_VEC, instr_valid=0, misalign_err=0, fetch_cnt=0, pending-redirect cleared. Any in-flight memory transaction is abandoned.
- IDLE state:
  - fetch_en=1 and pc_in[1:0]==0: go to ADDR.
  - fetch_en=1 and pc_in[1:0]!=0: set misalign_err, stay in IDLE, no request.
  - imem_rvalid is ignored here (covers stray responses after a reset).
- ADDR state:
  - imem_req=1 and imem_addr=pc_in, both held stable until imem_gnt.
  - gnt=1, rvalid=0: go to WAIT.
  - gnt=1 and rvalid=1 in the same cycle: capture directly, as in WAIT.
- WAIT state: imem_req=0. On rvalid, capture in the same edge:
  - instr ← rdata, instr_pc ← pc_in, PC_next ← pc_in+INCR (mod 2^XLEN), PCWrite=1 for exactly one cycle.
  - fetch_cnt increments; state goes to VALID.
- VALID state:
  - instr_valid=1; instr and instr_pc are stable.
  - On instr_ack: instr_valid=0 next cycle and state goes to IDLE. A new fetch starts no earlier than the cycle after.
- Redirect in IDLE or VALID:
  - Next cycle: PCWrite=1, PC_next=redirect_target, instr_valid=0, misalign_err=0, state IDLE.
  - Redirect beats instr_ack in the same cycle.
- Redirect in ADDR or WAIT:
  - Target is latched in the pending register. A later redirect overwrites it (last wins).
  - The current request still completes its handshake. On rvalid the data is discarded, fetch_cnt is unchanged, PCWrite=1 with PC_next=pending target, pending is cleared, state goes to IDLE.
  - Redirect in the same cycle as rvalid counts as pending: the data is discarded.
- PCWrite is never asserted for more than one consecutive cycle, and never in ADDR.
- Latency: fetch_en to instr_valid is 3 cycles with zero-wait memory (gnt in ADDR, rvalid the cycle after).

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, ADDR, WAIT, VALID}
  - XLEN_DEF=32, INCR_DEF=4, RESET_VEC_DEF=32'h0000_0020
- Single module, no sub-module: FSM, capture registers, pending-redirect register and counter all live in fetch_unit.

Test Plan:
- Reset, pc_in=0x20, fetch_en=1; memory gnt in ADDR, rvalid next cycle with rdata=0x00500093 → instr=0x00500093, instr_pc=0x20, PC_next=0x24 with PCWrite pulsed once, instr_valid=1, fetch_cnt=1.
- Same fetch with gnt delayed 3 cycles and rvalid 2 cycles after gnt → imem_req/imem_addr=0x20 held stable all 3 cycles; instr_valid 1 cycle after rvalid.
- redirect to 0x100 while in WAIT, then rvalid rdata=0xDEADBEEF → instr_valid stays 0, PCWrite with PC_next=0x100, fetch_cnt unchanged.
- In VALID, redirect(0x200) and instr_ack in the same cycle → PC_next=0x200, PCWrite=1, instr_valid=0, state IDLE.
- pc_in=0x22, fetch_en=1 → misalign_err=1, imem_req never asserted; redirect(0x40) clears misalign_err.
- rst asserted in WAIT, then stray rvalid → all outputs at reset values, instr_pc=0x20, no capture; fetch_cnt preset to 0xFFFFFFFF wraps to 0 after one delivery.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction-fetch sequencer
//
// Contents:
//   fetch_state_t  IDLE / ADDR / WAIT / VALID sequencer states
//   XLEN_DEF       default address/data width
//   INCR_DEF       default sequential PC increment in bytes
//   RESET_VEC_DEF  default reset value of instr_pc (PC register reset vector)
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  localparam int          XLEN_DEF      = 32;
  localparam int          INCR_DEF      = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0020;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch sequencer between PC register and instruction memory
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pc_in                           current PC from the PC register
//   PC_next, PCWrite                next PC and one-cycle load strobe to the PC register
//   fetch_en                        controller requests the next instruction
//   redirect, redirect_target       taken branch/jump pulse and its target
//   imem_req, imem_addr, imem_gnt   memory read request / address / accept
//   imem_rvalid, imem_rdata         memory read response
//   instr, instr_pc, instr_valid    captured instruction, its PC, valid until instr_ack
//   instr_ack                       controller consumed instr
//   misalign_err                    sticky misaligned-fetch flag
//   fetch_cnt                       delivered-instruction counter (wraps)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              INCR      = INCR_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_in,
  output logic [XLEN-1:0]  PC_next,
  output logic             PCWrite,
  input  logic             fetch_en,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_target,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic             instr_valid,
  input  logic             instr_ack,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_next_q, pc_next_d;
  logic             pc_write_q, pc_write_d;
  logic             imem_req_q, imem_req_d;
  logic [XLEN-1:0]  imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  instr_pc_q, instr_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic [XLEN-1:0]  pend_t_q, pend_t_d;

  // A redirect arriving this cycle overrides anything already pending (last wins).
  logic             redir_any;
  logic [XLEN-1:0]  redir_tgt;

  always_comb begin
    redir_any = redirect | pend_v_q;
    redir_tgt = redirect ? redirect_target : pend_t_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_next_d     = pc_next_q;
    pc_write_d    = 1'b0;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    cnt_d         = cnt_q;
    pend_v_d      = pend_v_q;
    pend_t_d      = pend_t_q;

    unique case (state_q)
      IDLE, VALID: begin
        if (redir_any) begin
          instr_valid_d = 1'b0;
          misalign_d    = 1'b0;
          state_d       = IDLE;
          if (pc_write_q) begin
            // PC load strobe is busy this cycle; park the target so PCWrite
            // never stays high for two consecutive cycles.
            pend_v_d = 1'b1;
            pend_t_d = redir_tgt;
          end else begin
            pc_write_d = 1'b1;
            pc_next_d  = redir_tgt;
            pend_v_d   = 1'b0;
          end
        end else if (state_q == VALID) begin
          if (instr_ack) begin
            instr_valid_d = 1'b0;
            misalign_d    = 1'b0;
            state_d       = IDLE;
          end
        end else begin
          if (instr_ack) begin
            misalign_d = 1'b0;
          end
          if (fetch_en) begin
            if (pc_in[1:0] == 2'b00) begin
              state_d     = ADDR;
              imem_req_d  = 1'b1;
              imem_addr_d = pc_in;
            end else begin
              misalign_d = 1'b1;
            end
          end
        end
      end

      ADDR, WAIT: begin
        if (redirect) begin
          pend_v_d = 1'b1;
          pend_t_d = redirect_target;
        end
        if (state_q == ADDR && imem_gnt) begin
          imem_req_d = 1'b0;
          state_d    = WAIT;
        end
        // rvalid only counts once the request has been granted (now or earlier).
        if ((state_q == WAIT || imem_gnt) && imem_rvalid) begin
          imem_req_d = 1'b0;
          pc_write_d = 1'b1;
          if (redir_any) begin
            pc_next_d = redir_tgt;
            pend_v_d  = 1'b0;
            state_d   = IDLE;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_in;
            pc_next_d     = pc_in + XLEN'(INCR);
            instr_valid_d = 1'b1;
            cnt_d         = cnt_q + CNT_W'(1);
            state_d       = VALID;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_next_q     <= '0;
      pc_write_q    <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_pc_q    <= RESET_VEC;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      cnt_q         <= '0;
      pend_v_q      <= 1'b0;
      pend_t_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_next_q     <= pc_next_d;
      pc_write_q    <= pc_write_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      cnt_q         <= cnt_d;
      pend_v_q      <= pend_v_d;
      pend_t_q      <= pend_t_d;
    end
  end

  assign PC_next      = pc_next_q;
  assign PCWrite      = pc_write_q;
  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a transaction-level reference model
module tb_fetch_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc_in = '0;
  logic [31:0]   PC_next;
  logic          PCWrite;
  logic          fetch_en = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_target = '0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ack = 1'b0;
  logic          misalign_err;
  logic [CW-1:0] fetch_cnt;

  fetch_unit #(.XLEN(32), .INCR(4), .RESET_VEC(32'h0000_0020), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .PC_next(PC_next), .PCWrite(PCWrite),
    .fetch_en(fetch_en), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    int          cnt;
  } deliv_t;

  logic [31:0] exp_pcw_q[$];
  deliv_t      exp_ins_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          model_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected PC loads and deliveries whenever the DUT presents them.
  logic iv_prev  = 1'b0;
  logic pcw_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      iv_prev  <= 1'b0;
      pcw_prev <= 1'b0;
    end else begin
      if (PCWrite) begin
        chk("pcwrite_single_cycle", 32'(pcw_prev), 32'd0);
        if (exp_pcw_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pcwrite: got PC_next %h expected no PCWrite", PC_next);
        end else begin
          chk("pc_next", PC_next, exp_pcw_q.pop_front());
        end
      end
      if (instr_valid && !iv_prev) begin
        if (exp_ins_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_instr: got instr %h expected no delivery", instr);
        end else begin
          deliv_t d;
          d = exp_ins_q.pop_front();
          chk("instr", instr, d.ins);
          chk("instr_pc", instr_pc, d.pc);
          chk("fetch_cnt", 32'(fetch_cnt), 32'(d.cnt));
        end
      end
      iv_prev  <= instr_valid;
      pcw_prev <= PCWrite;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pcwrite"}, 32'(PCWrite), 32'd0);
    chk({tag, "_pc_next"}, PC_next, 32'd0);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h20);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
    chk({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'd0);
  endtask

  // One fetch acting as controller + memory. gd: cycles in ADDR before gnt,
  // rd: cycles from gnt to rvalid (0 = same cycle). r1/r2: handshake step
  // (0 = first ADDR cycle) carrying a redirect, -1 for none.
  // end_mode: 0 ack, 1 redirect+ack, 2 redirect only.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input int gd, input int rd,
                          input int r1, input logic [31:0] t1,
                          input int r2, input logic [31:0] t2,
                          input int end_mode, input logic [31:0] end_tgt);
    int          steps;
    int          start;
    bit          redir_seen;
    logic [31:0] last_t;
    steps      = gd + rd;
    redir_seen = 0;
    last_t     = '0;
    pc_in      = pc;
    fetch_en   = 1'b1;
    start      = cyc;
    step();
    fetch_en = 1'b0;
    for (int s = 0; s <= steps; s++) begin
      chk("imem_req", 32'(imem_req), 32'(s <= gd));
      if (s <= gd) chk("imem_addr", imem_addr, pc);
      imem_gnt        = (s == gd);
      imem_rvalid     = (s == steps);
      imem_rdata      = (s == steps) ? data : $urandom;
      redirect        = (s == r1) || (s == r2);
      redirect_target = (s == r2) ? t2 : t1;
      if (redirect) begin
        redir_seen = 1;
        last_t     = redirect_target;
      end
      step();
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    if (redir_seen) begin
      exp_pcw_q.push_back(last_t);
      chk("discard_no_valid", 32'(instr_valid), 32'd0);
      step();
      return;
    end
    model_cnt = (model_cnt + 1) % (1 << CW);
    exp_pcw_q.push_back(pc + 32'd4);
    exp_ins_q.push_back('{ins: data, pc: pc, cnt: model_cnt});
    chk("instr_valid_set", 32'(instr_valid), 32'd1);
    if (gd == 0 && rd == 1) chk("latency", 32'(cyc - start), 32'd3);
    repeat ($urandom_range(1, 3)) step();
    chk("instr_valid_held", 32'(instr_valid), 32'd1);
    instr_ack       = (end_mode != 2);
    redirect        = (end_mode != 0);
    redirect_target = end_tgt;
    if (end_mode != 0) exp_pcw_q.push_back(end_tgt);
    step();
    instr_ack = 1'b0; redirect = 1'b0;
    chk("instr_valid_clr", 32'(instr_valid), 32'd0);
    step();
  endtask

  task automatic do_misalign(input logic [31:0] pc, input bit by_redirect, input logic [31:0] tgt);
    pc_in    = pc;
    fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("misalign_set", 32'(misalign_err), 32'd1);
      chk("misalign_no_req", 32'(imem_req), 32'd0);
    end
    fetch_en        = 1'b0;
    redirect        = by_redirect;
    instr_ack       = !by_redirect;
    redirect_target = tgt;
    if (by_redirect) exp_pcw_q.push_back(tgt);
    step();
    redirect = 1'b0; instr_ack = 1'b0;
    chk("misalign_clr", 32'(misalign_err), 32'd0);
    step();
  endtask

  task automatic do_reset_in_wait(input logic [31:0] pc);
    pc_in    = pc;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst      = 1'b1;
    step();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = $urandom;
    step();
    imem_rvalid = 1'b0;
    step();
    model_cnt = 0;
    chk_reset_outputs("rst_wait");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc, d, t1, t2;
    int gd, rd, r1, r2, kind, steps;
    rst = 1'b1;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    do_fetch(32'h20, 32'h0050_0093, 0, 1, -1, 0, -1, 0, 0, 0);
    do_fetch(32'h20, 32'h0050_0093, 3, 2, -1, 0, -1, 0, 0, 0);
    do_fetch(32'h24, 32'hDEAD_BEEF, 0, 2, 1, 32'h100, -1, 0, 0, 0);
    do_fetch(32'h100, 32'h1234_5678, 0, 1, -1, 0, -1, 0, 1, 32'h200);
    do_misalign(32'h22, 1'b1, 32'h40);
    do_reset_in_wait(32'h40);

    for (int n = 0; n < 60; n++) begin
      pc   = $urandom & 32'hFFFF_FFFC;
      d    = $urandom;
      t1   = $urandom;
      t2   = $urandom;
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      steps = gd + rd;
      if (kind <= 5) begin
        do_fetch(pc, d, gd, rd, -1, 0, -1, 0, $urandom_range(0, 2), t1);
      end else if (kind <= 7) begin
        r1 = $urandom_range(0, steps);
        r2 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(r1, steps)) : -1;
        do_fetch(pc, d, gd, rd, r1, t1, r2, t2, 0, 0);
      end else if (kind == 8) begin
        do_misalign(pc | 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), t1);
      end else begin
        do_reset_in_wait(pc);
      end
    end

    repeat (4) step();
    chk("pcw_queue_drained", 32'(exp_pcw_q.size()), 32'd0);
    chk("instr_queue_drained", 32'(exp_ins_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
